// File: rtl/mul_div_iter.sv
// Iterative RV64M multiply/divide unit for the EX stage: shift-add multiply, restoring divide,
// one bit per cycle, with a single-cycle fast path for divide-by-zero, signed overflow and illegal ops.
module mul_div_iter #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i,
   input  logic [3:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            stall_req_o,
   output logic            result_valid_o,
   output logic [XLEN-1:0] result_o
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

   state_t              r_state, w_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [3:0]          r_op;
   logic                r_neg_a, r_neg_b, r_fast;
   logic [XLEN-1:0]     r_fast_res, r_result;
   logic [XLEN-1:0]     r_hi, r_lo, r_b;

   // Incoming-op decode and operand preparation
   logic            w_in_word, w_in_div, w_in_illegal, w_in_sa, w_in_sb;
   logic            w_neg_a, w_neg_b, w_div0, w_ovf, w_fast, w_accept;
   logic [XLEN-1:0] w_a_sx32, w_b_sx32, w_a_ext, w_b_ext, w_a_abs, w_b_abs, w_a_src, w_fast_res;

   assign w_in_word    = op_i[3];
   assign w_in_div     = op_i[2];
   assign w_in_illegal = op_i[3] & ~op_i[2] & (op_i[1:0] != 2'b00);
   assign w_in_sa      = w_in_div ? ~op_i[0] : (op_i[1:0] != 2'b11);
   assign w_in_sb      = w_in_div ? ~op_i[0] : ~op_i[1];

   assign w_a_sx32 = {{(XLEN-32){rs1_i[31]}}, rs1_i[31:0]};
   assign w_b_sx32 = {{(XLEN-32){rs2_i[31]}}, rs2_i[31:0]};
   assign w_a_ext  = !w_in_word ? rs1_i : (w_in_sa ? w_a_sx32 : {{(XLEN-32){1'b0}}, rs1_i[31:0]});
   assign w_b_ext  = !w_in_word ? rs2_i : (w_in_sb ? w_b_sx32 : {{(XLEN-32){1'b0}}, rs2_i[31:0]});
   assign w_neg_a  = w_in_sa & w_a_ext[XLEN-1];
   assign w_neg_b  = w_in_sb & w_b_ext[XLEN-1];
   assign w_a_abs  = w_neg_a ? -w_a_ext : w_a_ext;
   assign w_b_abs  = w_neg_b ? -w_b_ext : w_b_ext;
   assign w_a_src  = w_in_word ? w_a_sx32 : rs1_i;

   assign w_div0   = w_in_div & (w_b_ext == '0);
   assign w_ovf    = w_in_div & w_in_sa & (w_b_ext == '1) & (w_a_ext == (w_in_word ? MIN_W : MIN_X));
   assign w_fast   = w_in_illegal | w_div0 | w_ovf;
   assign w_accept = (r_state == S_IDLE) & valid_i & ~flush_i;

   always_comb begin
      w_fast_res = '0;
      if (w_in_illegal)  w_fast_res = '0;
      else if (w_div0)   w_fast_res = op_i[1] ? w_a_src : '1;
      else if (w_ovf)    w_fast_res = op_i[1] ? '0 : w_a_src;
   end

   // One iteration step: multiply adds into the high half then shifts right,
   // divide shifts rem:quo left and conditionally subtracts.
   logic [XLEN:0]   w_sum, w_sh;
   logic [XLEN-1:0] w_sub;
   logic            w_ge;

   assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
   assign w_sh  = {r_hi, r_lo[XLEN-1]};
   assign w_ge  = w_sh >= {1'b0, r_b};
   assign w_sub = w_sh[XLEN-1:0] - r_b;

   // Result assembly with sign correction from the final accumulators
   logic [2*XLEN-1:0] w_prod, w_prod_mag, w_prod_s;
   logic [XLEN-1:0]   w_quo_s, w_rem_s, w_raw, w_final;

   assign w_prod     = {r_hi, r_lo};
   assign w_prod_mag = r_op[3] ? (w_prod >> 32) : w_prod;
   assign w_prod_s   = (r_neg_a ^ r_neg_b) ? -w_prod_mag : w_prod_mag;
   assign w_quo_s    = (r_neg_a ^ r_neg_b) ? -r_lo : r_lo;
   assign w_rem_s    = r_neg_a ? -r_hi : r_hi;
   assign w_raw      = r_op[2] ? (r_op[1] ? w_rem_s : w_quo_s)
                               : ((r_op[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN]);
   assign w_final    = r_fast ? r_fast_res
                     : (r_op[3] ? {{(XLEN-32){w_raw[31]}}, w_raw[31:0]} : w_raw);

   assign result_o = ((r_state == S_DONE) && !flush_i) ? w_final : r_result;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next         = r_state;
      stall_req_o    = 1'b0;
      result_valid_o = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (valid_i && !flush_i) begin
               stall_req_o = 1'b1;
               w_next      = w_fast ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            stall_req_o = ~flush_i;
            if (r_cnt == CNT_W'(1)) w_next = S_DONE;
         end
         S_DONE: begin
            result_valid_o = ~flush_i;
            w_next         = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      if (flush_i) w_next = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_op       <= '0;
         r_neg_a    <= 1'b0;
         r_neg_b    <= 1'b0;
         r_fast     <= 1'b0;
         r_fast_res <= '0;
         r_result   <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_b        <= '0;
      end else if (w_accept) begin
         r_op       <= op_i;
         r_neg_a    <= w_neg_a;
         r_neg_b    <= w_neg_b;
         r_fast     <= w_fast;
         r_fast_res <= w_fast_res;
         r_cnt      <= w_in_word ? CNT_W'(32) : CNT_W'(XLEN);
         r_hi       <= '0;
         r_b        <= w_in_div ? w_b_abs : w_a_abs;
         // Word divides start with the 32-bit dividend at the top so 32 shifts consume it
         r_lo       <= !w_in_div ? w_b_abs
                     : (w_in_word ? {w_a_abs[31:0], {(XLEN-32){1'b0}}} : w_a_abs);
      end else if (r_state == S_BUSY) begin
         r_cnt <= r_cnt - CNT_W'(1);
         if (r_op[2]) begin
            r_hi <= w_ge ? w_sub : w_sh[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], w_ge};
         end else begin
            r_hi <= w_sum[XLEN:1];
            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
         end
      end else if ((r_state == S_DONE) && !flush_i) begin
         r_result <= w_final;
      end
   end

endmodule

// File: tb/tb_mul_div_iter.sv
// Directed bench for mul_div_iter: results, latency, stall window, flush and reset behaviour.
module tb_mul_div_iter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_i = 1'b0;
   logic [3:0]  op_i = 4'd0;
   logic [63:0] rs1_i = 64'd0;
   logic [63:0] rs2_i = 64'd0;
   logic        flush_i = 1'b0;
   logic        stall_req_o;
   logic        result_valid_o;
   logic [63:0] result_o;

   int n_checks = 0;
   int n_fail   = 0;

   mul_div_iter #(.XLEN(64), .CNT_W(7)) dut (
      .clk            (clk),
      .rst            (rst),
      .valid_i        (valid_i),
      .op_i           (op_i),
      .rs1_i          (rs1_i),
      .rs2_i          (rs2_i),
      .flush_i        (flush_i),
      .stall_req_o    (stall_req_o),
      .result_valid_o (result_valid_o),
      .result_o       (result_o)
   );

   always #5 clk = ~clk;

   // Issue one op and hold it until the strobe; checks latency, stall window and result.
   task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int iters, input string name);
      int cyc, stall_cnt;
      bit done;
      @(negedge clk);
      valid_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; flush_i = 1'b0;
      #1;
      n_checks++;
      if (stall_req_o !== 1'b1 || result_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL %s accept: stall=%b strobe=%b, required stall=1 strobe=0", name, stall_req_o, result_valid_o);
      end
      stall_cnt = 1; cyc = 0; done = 0;
      while (!done && cyc < 200) begin
         @(negedge clk); #1;
         cyc++;
         if (result_valid_o === 1'b1) done = 1;
         else if (stall_req_o === 1'b1) stall_cnt++;
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s timeout: no strobe within 200 cycles", name);
      end else begin
         if (cyc != iters + 1) begin
            n_fail++;
            $display("FAIL %s latency: got %0d, required %0d", name, cyc, iters + 1);
         end
         n_checks++;
         if (stall_cnt != iters + 1 || stall_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s stall: cycles=%0d done_stall=%b, required %0d and 0", name, stall_cnt, stall_req_o, iters + 1);
         end
         n_checks++;
         if (result_o !== exp) begin
            n_fail++;
            $display("FAIL %s result: got %h, required %h", name, result_o, exp);
         end
      end
   endtask

   task automatic idle_check(input logic [63:0] hold, input int n, input string name);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         valid_i = 1'b0; flush_i = 1'b0;
         #1;
         n_checks++;
         if (result_valid_o !== 1'b0 || stall_req_o !== 1'b0 || result_o !== hold) begin
            n_fail++;
            $display("FAIL %s idle: strobe=%b stall=%b result=%h, required 0 0 %h",
                     name, result_valid_o, stall_req_o, result_o, hold);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk); #1;
         n_checks++;
         if (stall_req_o !== 1'b0 || result_valid_o !== 1'b0 || result_o !== 64'd0) begin
            n_fail++;
            $display("FAIL reset: stall=%b strobe=%b result=%h, required 0 0 0", stall_req_o, result_valid_o, result_o);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_mul();
      run_op(4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64, "mul_7x-3");
      run_op(4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64, "mulhu_max");
      run_op(4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64, "mulh_-1x-1");
      run_op(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, "mulhsu_-1x2");
   endtask

   task automatic test_div();
      run_op(4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64, "div_-7/2");
      run_op(4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, "rem_-7/2");
      run_op(4'd12, 64'h1_0000_0010, 64'd4, 64'd4, 32, "divw");
   endtask

   task automatic test_fast();
      run_op(4'd5, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, "divu_by0");
      run_op(4'd6, 64'd9, 64'd0, 64'd9, 0, "rem_by0");
      run_op(4'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0, "div_ovf");
      run_op(4'd14, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, "remw_ovf");
      run_op(4'd9, 64'd3, 64'd4, 64'd0, 0, "illegal");
   endtask

   task automatic test_flush_idle();
      @(negedge clk);
      valid_i = 1'b1; op_i = 4'd0; rs1_i = 64'd3; rs2_i = 64'd3; flush_i = 1'b1;
      #1;
      n_checks++;
      if (stall_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_idle stall: got %b, required 0", stall_req_o);
      end
      idle_check(64'd0, 3, "flush_idle");
   endtask

   task automatic test_flush_done();
      @(negedge clk);
      valid_i = 1'b1; op_i = 4'd5; rs1_i = 64'd5; rs2_i = 64'd0; flush_i = 1'b0;
      @(negedge clk);
      flush_i = 1'b1; valid_i = 1'b0;
      #1;
      n_checks++;
      if (result_valid_o !== 1'b0 || stall_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_done: strobe=%b stall=%b, required 0 0", result_valid_o, stall_req_o);
      end
      idle_check(64'd0, 2, "flush_done");
   endtask

   task automatic test_flush_busy();
      int strobes;
      @(negedge clk);
      valid_i = 1'b1; op_i = 4'd4; rs1_i = 64'd100; rs2_i = 64'd7; flush_i = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      n_checks++;
      if (stall_req_o !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_busy pre: stall=%b, required 1", stall_req_o);
      end
      flush_i = 1'b1;
      #1;
      n_checks++;
      if (stall_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_busy stall: got %b, required 0", stall_req_o);
      end
      @(negedge clk);
      flush_i = 1'b0; valid_i = 1'b0;
      strobes = 0;
      for (int i = 0; i < 70; i++) begin
         #1;
         if (result_valid_o === 1'b1 || stall_req_o === 1'b1) strobes++;
         @(negedge clk);
      end
      n_checks++;
      if (strobes != 0) begin
         n_fail++;
         $display("FAIL flush_busy after: %0d busy/strobe cycles, required 0", strobes);
      end
      run_op(4'd8, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32, "mulw");
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      valid_i = 1'b1; op_i = 4'd4; rs1_i = 64'd1000; rs2_i = 64'd3; flush_i = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      n_checks++;
      if (stall_req_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid pre: stall=%b, required 1", stall_req_o);
      end
      rst = 1'b1; valid_i = 1'b0;
      #1;
      n_checks++;
      if (stall_req_o !== 1'b0 || result_valid_o !== 1'b0 || result_o !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_mid: stall=%b strobe=%b result=%h, required 0 0 0", stall_req_o, result_valid_o, result_o);
      end
      @(negedge clk);
      rst = 1'b0;
      run_op(4'd7, 64'd10, 64'd3, 64'd1, 64, "remu_10/3");
   endtask

   task automatic test_back_to_back();
      run_op(4'd5, 64'd100, 64'd10, 64'd10, 64, "b2b_divu");
      run_op(4'd0, 64'd3, 64'd4, 64'd12, 64, "b2b_mul");
      run_op(4'd13, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32, "b2b_divuw");
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      idle_check(64'd4, 2, "hold_divw");
      test_fast();
      test_flush_idle();
      test_flush_done();
      test_flush_busy();
      test_reset_mid();
      test_back_to_back();
      idle_check(64'hFFFF_FFFF_FFFF_FFFF, 2, "hold_final");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
